hub75_framebuffer: RTL and testbench
====================================

// Module: hub75_framebuffer
// PURPOSE
//  Double-buffered RGB frame store that feeds the HUB75 scan stage in place of the procedural test pattern.
//  A producer streams one frame in raster order into the back bank (valid/ready).
//  The scan stage reads the front bank with its addrx/addry and gets the upper-half and lower-half pixels every cycle.
//  The banks swap only at a scan frame boundary, after the back frame is complete, so the panel never shows a torn frame.
// PARAMETERS
//  XBITS  7  column address width; panel width = 2**XBITS
//  YBITS  6  full-height row address width; rows per half = 2**(YBITS-1)
//  BPC    8  bits per colour channel
// PORTS
//  clk        in   1            pixel clock, same clock as the scan stage
//  rstn       in   1            asynchronous reset, active low
//  wr_valid   in   1            producer pixel valid
//  wr_ready   out  1            frame store accepts a pixel
//  wr_sof     in   1            qualifies the pixel as the first of a frame (x=0,y=0)
//  wr_r/g/b   in   BPC each     pixel colour
//  addrx      in   XBITS        scan column
//  addry      in   YBITS-1      scan row within a half
//  scan_vsync in   1            1-cycle pulse from the scan stage at its frame start
//  r0/g0/b0   out  BPC each     front-bank pixel (addrx, addry)
//  r1/g1/b1   out  BPC each     front-bank pixel (addrx, addry + 2**(YBITS-1))
//  front_bank out  1            bank currently displayed
//  swap_done  out  1            1-cycle pulse when the banks swap
// BEHAVIOUR
//  Reset values: front_bank=0; state FILL; write x=0, y=0; r0..b1=0; swap_done=0.
//  - wr_ready is high one cycle after reset is released. RAM contents are not cleared.
//  Read path: registered. Outputs change 1 cycle after addrx/addry and always read bank front_bank.
//  - After a swap, the first new-bank data appears on the cycle after the swap cycle.
//  Write path: wr_ready = (state==FILL). A pixel is taken when wr_valid && wr_ready.
//  - Target bank = ~front_bank.
//  - wr_y MSB selects the lower-half RAM. The remaining bits give the row within the half.
//  - wr_sof on an accepted pixel: that pixel goes to (0,0), then x=1, y=0. This also restarts a frame in progress.
//  - Non-sof pixels go to the current (x,y). x increments and wraps at 2**XBITS-1; on wrap, y increments.
//  - Unqualified valid-without-sof at power-up writes from (0,0).
//  States:
//  - FILL: on acceptance of pixel (2**XBITS-1, 2**YBITS-1) -> WAIT_SWAP, x=y=0.
//  - WAIT_SWAP: wr_ready=0. On scan_vsync, toggle front_bank, pulse swap_done -> FILL.
//  - WAIT_SWAP always waits for the next vsync: a vsync in the same cycle as the last pixel is ignored.
//  - scan_vsync in FILL is ignored, so the front bank is repeated until the producer finishes a frame.
//  - wr_sof asserted while in WAIT_SWAP is not accepted. The producer holds it until ready.
//  - Reset mid-frame discards the partial frame. The bank returns to 0 and the front-bank RAM data is kept.
//  Widths: RAM word = 3*BPC, ordered {b,g,r}. RAM address = {bank, row[YBITS-2:0], x[XBITS-1:0]}.
// STRUCTURE
//  hub75_pkg.vh: panel size defaults and BPC.
//  - Also holds localparams FB_FILL/FB_WAIT_SWAP and the {b,g,r} word-packing macro.
//  Sub-module fb_dpram (instantiated twice: upper and lower half).
//  - 1 write port, 1 registered read port, same clock.
//  - Depth 2**(XBITS+YBITS), width 3*BPC, written for ECP5 DP16KD inference.
//  - Read-during-write to the same address is don't-care; it cannot occur because read and write banks differ.
//  Top-level logic: write counters, 2-state FSM, bank flag, output unpacking.
// TESTING
//  1. Reset release, no writes, sweep addrx/addry -> wr_ready=1, front_bank=0, no swap_done even with scan_vsync pulses.
//  2. Stream one frame with pixel = {b=y,g=x,r=0x55}, sof on first.
//     -> wr_ready=0 after pixel 8191; next scan_vsync -> swap_done 1 cycle, front_bank=1.
//     -> addrx=5, addry=3 gives g0=5, b0=3, g1=5, b1=35 on the following cycle.
//  3. vsync in the same cycle as the last pixel -> no swap; swap occurs on the following vsync.
//  4. Assert wr_sof mid-frame at pixel 100, then a full frame -> swap happens only after 8192 pixels counted from the sof.
//     -> Data at (0,0) equals the sof pixel.
//  5. Producer stalls randomly (wr_valid duty 30%) while the scan stage reads continuously
//     -> front data stays constant until swap_done; no tearing against the reference model.
//  6. Assert rstn low mid-fill and in WAIT_SWAP -> outputs 0 immediately; FILL from (0,0) after release.

Source files
------------

// File: rtl/hub75_framebuffer_pkg.sv
// Shared definitions for the HUB75 double-buffered frame store.
// Holds the default panel geometry, the colour depth and the state type of
// the write-side state machine.
package hub75_framebuffer_pkg;

  // Default panel: 128 columns x 64 rows, 8 bits per colour channel.
  localparam int unsigned FbXBits = 7;
  localparam int unsigned FbYBits = 6;
  localparam int unsigned FbBpc   = 8;

  // FbFill: the back bank is accepting pixels.
  // FbWaitSwap: the back frame is complete and waits for the scan frame boundary.
  typedef enum logic {
    FbFill     = 1'b0,
    FbWaitSwap = 1'b1
  } fb_state_e;

endpackage

// File: rtl/hub75_framebuffer_dpram.sv
// Simple dual-port RAM: one write port and one registered read port on a
// single clock. Shaped so that the array maps onto ECP5 DP16KD block RAM.
// Only the read register is reset; the array contents survive reset.
// Ports:
//   clk, rstn     clock and asynchronous active-low reset (read register only)
//   we/waddr/wdata  write port
//   raddr/rdata     read port, rdata valid one cycle after raddr
module hub75_framebuffer_dpram #(
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned DataWidth = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [2**AddrWidth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read and write always target different banks, so read-during-write
  // ordering never matters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hub75_framebuffer.sv
// Double-buffered RGB frame store feeding the HUB75 scan stage.
// A producer streams a frame in raster order into the back bank; the scan
// stage reads the front bank and receives the upper-half and lower-half
// pixel of the addressed column/row every cycle. Banks swap only on a scan
// vsync after the back frame is complete, so the panel never tears.
// Ports:
//   clk, rstn              pixel clock, asynchronous active-low reset
//   wr_valid/wr_ready      producer handshake, wr_sof marks pixel (0,0)
//   wr_r/wr_g/wr_b         producer pixel colour
//   addrx/addry            scan column / row within a half
//   scan_vsync             1-cycle scan frame-start pulse
//   r0/g0/b0, r1/g1/b1     upper / lower half pixel, one cycle after the address
//   front_bank, swap_done  displayed bank, 1-cycle pulse on each swap
module hub75_framebuffer
  import hub75_framebuffer_pkg::*;
#(
  parameter int unsigned XBITS = FbXBits,
  parameter int unsigned YBITS = FbYBits,
  parameter int unsigned BPC   = FbBpc
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_sof,
  input  logic [BPC-1:0]   wr_r,
  input  logic [BPC-1:0]   wr_g,
  input  logic [BPC-1:0]   wr_b,
  input  logic [XBITS-1:0] addrx,
  input  logic [YBITS-2:0] addry,
  input  logic             scan_vsync,
  output logic [BPC-1:0]   r0,
  output logic [BPC-1:0]   g0,
  output logic [BPC-1:0]   b0,
  output logic [BPC-1:0]   r1,
  output logic [BPC-1:0]   g1,
  output logic [BPC-1:0]   b1,
  output logic             front_bank,
  output logic             swap_done
);

  localparam int unsigned AW = XBITS + YBITS;
  localparam int unsigned DW = 3 * BPC;
  localparam logic [XBITS-1:0] XMax = '1;
  localparam logic [YBITS-1:0] YMax = '1;

  fb_state_e        state;
  logic [XBITS-1:0] wr_x;
  logic [YBITS-1:0] wr_y;

  logic             accept;
  logic [XBITS-1:0] px;
  logic [YBITS-1:0] py;
  logic             last_px;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rd_upper;
  logic [DW-1:0]    rd_lower;

  assign accept  = wr_valid && wr_ready;
  // A sof pixel always lands on (0,0), restarting any frame in progress.
  assign px      = wr_sof ? '0 : wr_x;
  assign py      = wr_sof ? '0 : wr_y;
  assign last_px = (px == XMax) && (py == YMax);

  // The row MSB picks the half-RAM; each RAM holds both banks.
  assign waddr = {~front_bank, py[YBITS-2:0], px};
  assign raddr = {front_bank, addry, addrx};
  assign wdata = {wr_b, wr_g, wr_r};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FbFill;
      wr_x       <= '0;
      wr_y       <= '0;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        FbFill: begin
          wr_ready <= 1'b1;
          if (accept) begin
            if (last_px) begin
              state    <= FbWaitSwap;
              wr_x     <= '0;
              wr_y     <= '0;
              wr_ready <= 1'b0;
            end else begin
              wr_x <= px + XBITS'(1);
              wr_y <= (px == XMax) ? py + YBITS'(1) : py;
            end
          end
        end
        FbWaitSwap: begin
          // Entered on the last-pixel edge, so a vsync coincident with that
          // pixel is never seen here.
          if (scan_vsync) begin
            front_bank <= ~front_bank;
            swap_done  <= 1'b1;
            state      <= FbFill;
            wr_ready   <= 1'b1;
          end
        end
        default: state <= FbFill;
      endcase
    end
  end

  hub75_framebuffer_dpram #(
    .AddrWidth(AW),
    .DataWidth(DW)
  ) u_ram_upper (
    .clk  (clk),
    .rstn (rstn),
    .we   (accept && !py[YBITS-1]),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rd_upper)
  );

  hub75_framebuffer_dpram #(
    .AddrWidth(AW),
    .DataWidth(DW)
  ) u_ram_lower (
    .clk  (clk),
    .rstn (rstn),
    .we   (accept && py[YBITS-1]),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rd_lower)
  );

  assign {b0, g0, r0} = rd_upper;
  assign {b1, g1, r1} = rd_lower;

endmodule

// File: tb/tb_hub75_framebuffer.sv
// Self-checking bench for hub75_framebuffer (default 128x64 panel, 8 bpc).
module tb_hub75_framebuffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_sof = 1'b0;
  logic [7:0] wr_r = '0;
  logic [7:0] wr_g = '0;
  logic [7:0] wr_b = '0;
  logic [6:0] addrx = '0;
  logic [4:0] addry = '0;
  logic       scan_vsync = 1'b0;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       front_bank;
  logic       swap_done;

  int n_cmp = 0;
  int n_err = 0;
  int swap_cnt = 0;

  always #5 clk = ~clk;

  hub75_framebuffer dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sof    (wr_sof),
    .wr_r      (wr_r),
    .wr_g      (wr_g),
    .wr_b      (wr_b),
    .addrx     (addrx),
    .addry     (addry),
    .scan_vsync(scan_vsync),
    .r0        (r0),
    .g0        (g0),
    .b0        (b0),
    .r1        (r1),
    .g1        (g1),
    .b1        (b1),
    .front_bank(front_bank),
    .swap_done (swap_done)
  );

  always @(negedge clk) if (swap_done) swap_cnt = swap_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pixel patterns, packed {b,g,r}.
  function automatic logic [23:0] pat(input int p, input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = x[7:0];
    yb = y[7:0];
    case (p)
      1:       return {yb, xb, 8'h55};
      2:       return {yb + 8'd64, xb, 8'hAA};
      3:       return {yb, xb, 8'h11};
      4:       return {yb + yb, xb + 8'd1, 8'h33};
      5:       return {yb, xb, 8'h77};
      default: return {yb + 8'd1, xb, 8'h99};
    endcase
  endfunction

  // Contents of bank 1 after the sof-restart frame.
  function automatic logic [23:0] bank1_word(input int x, input int y);
    if (x == 0 && y == 0) return 24'hEEEEEE;
    return pat(3, x, y);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_px(input logic sof, input logic [23:0] w, input logic vs);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_sof = sof;
    {wr_b, wr_g, wr_r} = w;
    if (vs) scan_vsync = 1'b1;
    while (!wr_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) check_eq("ready_timeout", n, 0);
    tick(1);
    wr_valid = 1'b0;
    wr_sof = 1'b0;
    if (vs) scan_vsync = 1'b0;
  endtask

  task automatic send_range(input int p, input int start, input int count,
                            input logic sof_first, input logic vs_last);
    for (int i = start; i < start + count; i++) begin
      send_px(sof_first && (i == start), pat(p, i % 128, i / 128),
              vs_last && (i == start + count - 1));
    end
  endtask

  task automatic pulse_vsync();
    scan_vsync = 1'b1;
    tick(1);
    scan_vsync = 1'b0;
  endtask

  task automatic chk_pix(input string tag, input int x, input int y,
                         input logic [23:0] e0, input logic [23:0] e1);
    addrx = x[6:0];
    addry = y[4:0];
    tick(1);
    check_eq({tag, "_up"}, {b0, g0, r0}, e0);
    check_eq({tag, "_lo"}, {b1, g1, r1}, e1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;

    // 1: reset values, ready latency, vsync ignored without a frame
    #12;
    check_eq("rst_out0", {b0, g0, r0}, 0);
    check_eq("rst_out1", {b1, g1, r1}, 0);
    check_eq("rst_front", front_bank, 0);
    check_eq("rst_swap", swap_done, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_eq("ready_at_release", wr_ready, 0);
    tick(1);
    check_eq("ready_after_1", wr_ready, 1);
    s0 = swap_cnt;
    for (int i = 0; i < 40; i++) begin
      addrx = 7'(i * 3);
      addry = 5'(i);
      scan_vsync = (i % 8 == 0);
      tick(1);
    end
    scan_vsync = 1'b0;
    tick(1);
    check_eq("t1_no_swap", swap_cnt - s0, 0);
    check_eq("t1_front", front_bank, 0);
    check_eq("t1_ready", wr_ready, 1);

    // 2: one full frame then swap on the next vsync
    send_range(1, 0, 8192, 1'b1, 1'b0);
    check_eq("t2_ready_low", wr_ready, 0);
    tick(3);
    check_eq("t2_wait_front", front_bank, 0);
    pulse_vsync();
    check_eq("t2_swap_pulse", swap_done, 1);
    check_eq("t2_front", front_bank, 1);
    chk_pix("t2_px53", 5, 3, 24'h030555, 24'h230555);
    check_eq("t2_swap_1cyc", swap_done, 0);
    check_eq("t2_ready_back", wr_ready, 1);
    chk_pix("t2_px127_31", 127, 31, 24'h1F7F55, 24'h3F7F55);

    // 3: vsync coincident with the last pixel is ignored
    s0 = swap_cnt;
    send_range(2, 0, 8192, 1'b1, 1'b1);
    tick(3);
    check_eq("t3_no_swap", swap_cnt - s0, 0);
    check_eq("t3_front_held", front_bank, 1);
    check_eq("t3_ready_low", wr_ready, 0);
    pulse_vsync();
    check_eq("t3_swap", swap_done, 1);
    check_eq("t3_front", front_bank, 0);
    chk_pix("t3_px53", 5, 3, 24'h4305AA, 24'h6305AA);

    // 4: sof mid-frame restarts the count
    send_range(3, 0, 100, 1'b1, 1'b0);
    send_px(1'b1, 24'hEEEEEE, 1'b0);
    send_range(3, 1, 8190, 1'b0, 1'b0);
    check_eq("t4_not_done", wr_ready, 1);
    send_range(3, 8191, 1, 1'b0, 1'b0);
    check_eq("t4_done", wr_ready, 0);
    pulse_vsync();
    check_eq("t4_front", front_bank, 1);
    chk_pix("t4_px00", 0, 0, 24'hEEEEEE, 24'h200011);
    chk_pix("t4_px10", 1, 0, 24'h000111, 24'h200111);

    // 5: stalled producer, continuous scan, tearing check
    s0 = swap_cnt;
    fork
      begin : producer
        for (int i = 0; i < 8192; i++) begin
          while ($urandom_range(0, 9) >= 3) tick(1);
          send_px(i == 0, pat(4, i % 128, i / 128), 1'b0);
        end
      end
      begin : reader
        int cyc;
        int tear;
        int post;
        logic [6:0] ax;
        logic [4:0] ay;
        logic fbp;
        logic [23:0] e0;
        logic [23:0] e1;
        cyc = 0;
        tear = 0;
        post = 0;
        ax = '0;
        ay = '0;
        addrx = ax;
        addry = ay;
        fbp = front_bank;
        while (cyc < 60000 && post < 4) begin
          tick(1);
          cyc++;
          if (fbp) begin
            e0 = bank1_word(int'(ax), int'(ay));
            e1 = bank1_word(int'(ax), int'(ay) + 32);
          end else begin
            e0 = pat(4, int'(ax), int'(ay));
            e1 = pat(4, int'(ax), int'(ay) + 32);
          end
          if ({b0, g0, r0} !== e0 || {b1, g1, r1} !== e1) tear++;
          if (swap_cnt != s0) post++;
          scan_vsync = (cyc % 300 == 0);
          ax = ax + 7'd1;
          ay = ay + 5'd3;
          addrx = ax;
          addry = ay;
          fbp = front_bank;
        end
        scan_vsync = 1'b0;
        check_eq("t5_tear", tear, 0);
        check_eq("t5_in_time", (cyc < 60000) ? 1 : 0, 1);
      end
    join
    check_eq("t5_swaps", swap_cnt - s0, 1);
    check_eq("t5_front", front_bank, 0);
    chk_pix("t5_px53", 5, 3, 24'h060633, 24'h460633);

    // 6a: reset mid-fill discards the partial frame
    send_range(6, 0, 50, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("t6a_out0", {b0, g0, r0}, 0);
    check_eq("t6a_out1", {b1, g1, r1}, 0);
    check_eq("t6a_front", front_bank, 0);
    tick(2);
    rstn = 1'b1;
    tick(2);
    check_eq("t6a_ready", wr_ready, 1);
    chk_pix("t6a_kept", 5, 3, 24'h060633, 24'h460633);
    // No sof: must still start at (0,0)
    send_range(5, 0, 8192, 1'b0, 1'b0);
    check_eq("t6a_done", wr_ready, 0);
    pulse_vsync();
    check_eq("t6a_swap_front", front_bank, 1);
    chk_pix("t6a_px00", 0, 0, 24'h000077, 24'h200077);
    chk_pix("t6a_px127_31", 127, 31, 24'h1F7F77, 24'h3F7F77);

    // 6b: reset while waiting for the swap
    send_range(6, 0, 8192, 1'b1, 1'b0);
    check_eq("t6b_wait", wr_ready, 0);
    rstn = 1'b0;
    #1;
    check_eq("t6b_out0", {b0, g0, r0}, 0);
    check_eq("t6b_front", front_bank, 0);
    tick(2);
    rstn = 1'b1;
    tick(2);
    check_eq("t6b_ready", wr_ready, 1);
    check_eq("t6b_front_after", front_bank, 0);
    chk_pix("t6b_bank0", 5, 3, 24'h040599, 24'h240599);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
